// File: rtl/board_reg_bank.sv
// board_reg_bank: 2048 board storage with whole-board load, single-cell
// spawn write and a circular undo history of DEPTH snapshots.
module board_reg_bank #(
    parameter int CELLS = 16,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Load,
    input  logic [CELLS*WIDTH-1:0]     D,
    input  logic                       Wr_en,
    input  logic [$clog2(CELLS)-1:0]   Wr_idx,
    input  logic [WIDTH-1:0]           Wr_data,
    input  logic                       Undo,
    output logic [CELLS*WIDTH-1:0]     Data_Out,
    output logic                       Changed,
    output logic                       Undo_avail,
    output logic [$clog2(DEPTH+1)-1:0] Hist_count,
    output logic                       Undo_err
);

    localparam int BW = CELLS * WIDTH;
    localparam int IW = $clog2(CELLS);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BW-1:0] hist [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_inc;
    logic [PW-1:0] next_ptr;
    logic [CW-1:0] next_count;
    logic [BW-1:0] wr_board;
    logic          hist_empty;
    logic          hist_full;
    logic          do_undo;
    logic          do_err;
    logic          do_load;
    logic          do_wr;

    // Pointer arithmetic: wr_ptr is the next push slot, newest entry sits just
    // behind it. When full, wr_ptr lands on the oldest entry, so a push there
    // overwrites it naturally.
    always_comb begin
        rd_ptr     = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
        wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        hist_empty = (Hist_count == '0);
        hist_full  = (Hist_count == CW'(DEPTH));
    end

    // Command decode with priority Undo > Load > Wr_en; Reset handled in the register.
    always_comb begin
        do_undo = Undo && !hist_empty;
        do_err  = Undo && hist_empty;
        do_load = !Undo && Load && (D != Data_Out);
        do_wr   = !Undo && !Load && Wr_en;
    end

    // Next history count and pointer for the accepted command.
    always_comb begin
        next_count = Hist_count;
        next_ptr   = wr_ptr;
        if (do_undo) begin
            next_count = Hist_count - 1'b1;
            next_ptr   = rd_ptr;
        end else if (do_load) begin
            next_ptr = wr_ptr_inc;
            if (!hist_full) begin
                next_count = Hist_count + 1'b1;
            end
        end
    end

    // Board with one cell replaced; an out-of-range index matches no cell.
    always_comb begin
        wr_board = Data_Out;
        for (int i = 0; i < CELLS; i++) begin
            if (Wr_idx == IW'(i)) begin
                wr_board[i*WIDTH +: WIDTH] = Wr_data;
            end
        end
    end

    // Board, history bookkeeping and status pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_Out   <= '0;
            Hist_count <= '0;
            Undo_avail <= 1'b0;
            Changed    <= 1'b0;
            Undo_err   <= 1'b0;
            wr_ptr     <= '0;
        end else begin
            if (do_undo) begin
                Data_Out <= hist[rd_ptr];
            end else if (do_load) begin
                Data_Out <= D;
            end else if (do_wr) begin
                Data_Out <= wr_board;
            end
            Hist_count <= next_count;
            Undo_avail <= (next_count != '0);
            Changed    <= do_load;
            Undo_err   <= do_err;
            wr_ptr     <= next_ptr;
        end
    end

    // Snapshot storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge Clk) begin
        if (!Reset && do_load) begin
            hist[wr_ptr] <= Data_Out;
        end
    end

endmodule

// File: tb/tb_board_reg_bank.sv
// Self-checking bench for board_reg_bank: a behavioural model pushes the
// expected post-edge state into a scoreboard, each test pops and compares.
module tb_board_reg_bank;

    localparam int CELLS = 16;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int BW    = CELLS * WIDTH;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Load = 1'b0;
    logic [BW-1:0] D = '0;
    logic          Wr_en = 1'b0;
    logic [3:0]    Wr_idx = '0;
    logic [3:0]    Wr_data = '0;
    logic          Undo = 1'b0;
    logic [BW-1:0] Data_Out;
    logic          Changed;
    logic          Undo_avail;
    logic [2:0]    Hist_count;
    logic          Undo_err;

    typedef struct packed {
        logic [BW-1:0] board;
        logic [2:0]    count;
        logic          avail;
        logic          changed;
        logic          err;
    } exp_t;

    exp_t          sb [$];
    exp_t          e;
    logic [BW-1:0] m_board;
    logic [BW-1:0] m_hist [$];
    logic          m_changed;
    logic          m_err;
    int            vectors = 0;
    int            miscompares = 0;
    logic [BW-1:0] b [0:6];
    logic [BW-1:0] saved;

    board_reg_bank #(.CELLS(CELLS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load       (Load),
        .D          (D),
        .Wr_en      (Wr_en),
        .Wr_idx     (Wr_idx),
        .Wr_data    (Wr_data),
        .Undo       (Undo),
        .Data_Out   (Data_Out),
        .Changed    (Changed),
        .Undo_avail (Undo_avail),
        .Hist_count (Hist_count),
        .Undo_err   (Undo_err)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of commands, update the model, queue the expectation,
    // then step past the edge so outputs are stable for sampling.
    task automatic apply(input logic rst, input logic u, input logic l,
                         input logic [BW-1:0] d, input logic w,
                         input logic [3:0] idx, input logic [3:0] dat);
        Reset = rst; Undo = u; Load = l; D = d;
        Wr_en = w; Wr_idx = idx; Wr_data = dat;
        m_changed = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_board = '0;
            m_hist.delete();
        end else if (u) begin
            if (m_hist.size() > 0) m_board = m_hist.pop_back();
            else m_err = 1'b1;
        end else if (l) begin
            if (d !== m_board) begin
                m_hist.push_back(m_board);
                if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
                m_board = d;
                m_changed = 1'b1;
            end
        end else if (w) begin
            if (int'(idx) < CELLS) m_board[int'(idx)*WIDTH +: WIDTH] = dat;
        end
        sb.push_back('{m_board, 3'(m_hist.size()), m_hist.size() != 0,
                       m_changed, m_err});
        @(posedge Clk);
        #1;
        Reset = 1'b0; Undo = 1'b0; Load = 1'b0; Wr_en = 1'b0;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 4'd0, 4'd0);
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== '0) begin
            miscompares++;
            $display("FAIL reset_board got %h want 0", Data_Out);
        end
        vectors++;
        if (Hist_count !== 3'd0 || Undo_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hist got cnt=%0d avail=%b want 0/0", Hist_count, Undo_avail);
        end
        vectors++;
        if (Changed !== 1'b0 || Undo_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pulses got chg=%b err=%b want 0/0", Changed, Undo_err);
        end
    endtask

    task automatic test_spawn_move();
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd5, 4'd1);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== e.board || Hist_count !== 3'd0) begin
            miscompares++;
            $display("FAIL spawn got %h cnt=%0d want %h cnt=0", Data_Out, Hist_count, e.board);
        end
        apply(1'b0, 1'b0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== 64'h0000_0000_0001_0000 || Data_Out !== e.board) begin
            miscompares++;
            $display("FAIL move_board got %h want %h", Data_Out, e.board);
        end
        vectors++;
        if (Changed !== 1'b1 || Hist_count !== 3'd1 || Undo_avail !== 1'b1) begin
            miscompares++;
            $display("FAIL move_status got chg=%b cnt=%0d avail=%b want 1/1/1", Changed, Hist_count, Undo_avail);
        end
        idle();
        e = sb.pop_front();
        vectors++;
        if (Changed !== e.changed) begin
            miscompares++;
            $display("FAIL move_pulse got chg=%b want %b", Changed, e.changed);
        end
    endtask

    task automatic test_noop_move();
        apply(1'b0, 1'b0, 1'b1, m_board, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Changed !== 1'b0 || Hist_count !== e.count || Data_Out !== e.board) begin
            miscompares++;
            $display("FAIL noop got chg=%b cnt=%0d brd=%h want 0 %0d %h", Changed, Hist_count, Data_Out, e.count, e.board);
        end
    endtask

    task automatic test_overflow_undo();
        b[0] = m_board;
        for (int k = 1; k <= 6; k++) begin
            b[k] = {16{4'(k)}};
            apply(1'b0, 1'b0, 1'b1, b[k], 1'b0, 4'd0, 4'd0);
            e = sb.pop_front();
            vectors++;
            if (Data_Out !== b[k] || Changed !== 1'b1) begin
                miscompares++;
                $display("FAIL ovf_load%0d got %h chg=%b want %h 1", k, Data_Out, Changed, b[k]);
            end
        end
        vectors++;
        if (Hist_count !== 3'd4 || Hist_count !== e.count) begin
            miscompares++;
            $display("FAIL ovf_count got %0d want 4", Hist_count);
        end
        for (int k = 5; k >= 2; k--) begin
            apply(1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);
            e = sb.pop_front();
            vectors++;
            if (Data_Out !== b[k] || Data_Out !== e.board || Changed !== 1'b0) begin
                miscompares++;
                $display("FAIL undo_B%0d got %h chg=%b want %h 0", k, Data_Out, Changed, b[k]);
            end
        end
        apply(1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Undo_err !== 1'b1 || Data_Out !== b[2] || Undo_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL undo_empty got err=%b brd=%h avail=%b want 1 %h 0", Undo_err, Data_Out, Undo_avail, b[2]);
        end
        idle();
        e = sb.pop_front();
        vectors++;
        if (Undo_err !== e.err) begin
            miscompares++;
            $display("FAIL undo_err_pulse got %b want %b", Undo_err, e.err);
        end
    endtask

    task automatic test_priority();
        saved = m_board;
        apply(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        apply(1'b0, 1'b1, 1'b1, 64'h5555_5555_5555_5555, 1'b1, 4'd3, 4'd9);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== saved || Changed !== 1'b0 || Hist_count !== 3'd0) begin
            miscompares++;
            $display("FAIL prio_undo got %h chg=%b cnt=%0d want %h 0 0", Data_Out, Changed, Hist_count, saved);
        end
        apply(1'b0, 1'b0, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 4'd1, 4'd7);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== 64'h0F0F_0F0F_0F0F_0F0F || Hist_count !== e.count) begin
            miscompares++;
            $display("FAIL prio_load got %h cnt=%0d want 0f0f0f0f0f0f0f0f %0d", Data_Out, Hist_count, e.count);
        end
        apply(1'b0, 1'b0, 1'b0, '0, 1'b1, 4'd15, 4'hA);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== 64'hAF0F_0F0F_0F0F_0F0F || Changed !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_top got %h chg=%b want af0f0f0f0f0f0f0f 0", Data_Out, Changed);
        end
    endtask

    task automatic test_back_to_back();
        saved = m_board;
        apply(1'b0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        apply(1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== saved) begin
            miscompares++;
            $display("FAIL b2b_undo got %h want %h", Data_Out, saved);
        end
        apply(1'b0, 1'b0, 1'b1, 64'h0000_1111_2222_3333, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        apply(1'b0, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== saved || Hist_count !== e.count) begin
            miscompares++;
            $display("FAIL no_redo got %h cnt=%0d want %h %0d", Data_Out, Hist_count, saved, e.count);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 3; k++) begin
            apply(1'b0, 1'b0, 1'b1, {16{4'(k + 8)}}, 1'b0, 4'd0, 4'd0);
            e = sb.pop_front();
        end
        vectors++;
        if (Hist_count !== e.count) begin
            miscompares++;
            $display("FAIL mid_count got %0d want %0d", Hist_count, e.count);
        end
        apply(1'b1, 1'b1, 1'b0, '0, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Hist_count !== 3'd0 || Data_Out !== '0 || Undo_err !== 1'b0 || Undo_avail !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset got cnt=%0d brd=%h err=%b avail=%b want 0 0 0 0", Hist_count, Data_Out, Undo_err, Undo_avail);
        end
        apply(1'b0, 1'b0, 1'b1, 64'h7, 1'b0, 4'd0, 4'd0);
        e = sb.pop_front();
        vectors++;
        if (Data_Out !== 64'h7 || Hist_count !== 3'd1 || Changed !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset got %h cnt=%0d chg=%b want 7 1 1", Data_Out, Hist_count, Changed);
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] d;
        for (int n = 0; n < 400; n++) begin
            d = (($urandom_range(0, 3) == 0) ? m_board : {$urandom, $urandom});
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, d, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            e = sb.pop_front();
            vectors++;
            if (Data_Out !== e.board || Hist_count !== e.count || Undo_avail !== e.avail
                || Changed !== e.changed || Undo_err !== e.err) begin
                miscompares++;
                $display("FAIL rand%0d got %h %0d %b %b %b want %h %0d %b %b %b", n,
                         Data_Out, Hist_count, Undo_avail, Changed, Undo_err,
                         e.board, e.count, e.avail, e.changed, e.err);
            end
        end
    endtask

    initial begin
        m_board = '0;
        @(negedge Clk);
        test_reset();
        test_spawn_move();
        test_noop_move();
        test_overflow_undo();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
